// File: rtl/regfile_wport_arbiter_if.sv
// rtl/regfile_wport_arbiter_if.sv - bus bundle for the register-file write-port arbiter
//
// Purpose: groups the WB-stage request, long-latency result handshake,
// register-file write port, stall request and hazard-check signals.
// Ports (signals):
//   wb_we/wb_addr/wb_data       WB stage write request (master -> slave)
//   lu_valid/lu_addr/lu_data    long-latency result (master -> slave)
//   lu_ready                    FIFO can accept a result (slave -> master)
//   rf_we/rf_waddr/rf_wdata     register file write port (slave -> master)
//   stall_req                   one-cycle WB freeze request (slave -> master)
//   chk_addr1/2, pend_hit1/2    pending-write hazard lookup
//   fifo_count                  occupied FIFO entries
interface regfile_wport_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_addr;
  logic [DATA_W-1:0] lu_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              stall_req;
  logic [ADDR_W-1:0] chk_addr1;
  logic [ADDR_W-1:0] chk_addr2;
  logic              pend_hit1;
  logic              pend_hit2;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output wb_we, wb_addr, wb_data,
    output lu_valid, lu_addr, lu_data,
    input  lu_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  stall_req,
    output chk_addr1, chk_addr2,
    input  pend_hit1, pend_hit2,
    input  fifo_count
  );

  modport slave (
    input  wb_we, wb_addr, wb_data,
    input  lu_valid, lu_addr, lu_data,
    output lu_ready,
    output rf_we, rf_waddr, rf_wdata,
    output stall_req,
    input  chk_addr1, chk_addr2,
    output pend_hit1, pend_hit2,
    output fifo_count
  );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// rtl/regfile_wport_arbiter.sv - register-file write-port arbiter between WB and long-latency unit
//
// Purpose: WB owns the single write port with fixed priority; long-latency
// results are parked in a small FIFO and drain into cycles WB leaves idle.
// A starvation counter raises stall_req once the FIFO head has been blocked
// STARVE_MAX cycles in a row. pend_hit flags reads of registers whose write
// is still parked.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   bus   regfile_wport_arbiter_if.slave (all handshake, write port and hazard signals)
module regfile_wport_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  regfile_wport_arbiter_if.slave       bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ST_W-1:0]  starve_q, starve_d;

  logic wb_claim;
  logic fifo_empty;
  logic push;
  logic pop;

  // Address 0 is the hard-wired zero register; writes to it are no-ops.
  assign wb_claim   = bus.wb_we && (bus.wb_addr != '0);
  assign fifo_empty = (cnt_q == '0);
  assign bus.lu_ready = (cnt_q < CNT_W'(DEPTH));

  // Accepted results to r0 are dropped, never parked.
  assign push = bus.lu_valid && bus.lu_ready && (bus.lu_addr != '0);
  assign pop  = rst && !wb_claim && !fifo_empty;

  // rst gating keeps the register file untouched while reset is held,
  // even if WB keeps requesting.
  assign bus.rf_we    = rst && (wb_claim || !fifo_empty);
  assign bus.rf_waddr = wb_claim ? bus.wb_addr : addr_mem[rptr_q];
  assign bus.rf_wdata = wb_claim ? bus.wb_data : data_mem[rptr_q];

  assign bus.stall_req  = (starve_q == ST_W'(STARVE_MAX));
  assign bus.fifo_count = cnt_q;

  always_comb begin
    wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Counts only cycles where a parked head is actually blocked by WB.
  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (wb_claim && (starve_q != ST_W'(STARVE_MAX))) begin
      starve_d = starve_q + ST_W'(1);
    end
  end

  // Scan entries from the head; only the first cnt_q slots hold live writes.
  always_comb begin
    logic [PTR_W-1:0] idx;
    bus.pend_hit1 = 1'b0;
    bus.pend_hit2 = 1'b0;
    idx = rptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr_q + PTR_W'(k);
      if (CNT_W'(k) < cnt_q) begin
        if ((bus.chk_addr1 != '0) && (addr_mem[idx] == bus.chk_addr1)) bus.pend_hit1 = 1'b1;
        if ((bus.chk_addr2 != '0) && (addr_mem[idx] == bus.chk_addr2)) bus.pend_hit2 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wptr_q] <= bus.lu_addr;
      data_mem[wptr_q] <= bus.lu_data;
    end
  end
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb/tb_regfile_wport_arbiter.sv - scoreboard testbench for regfile_wport_arbiter
module tb_regfile_wport_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;
  localparam int SMAX   = 4;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   starve = 0;
  wr_t  lu_q[$];
  wr_t  wb_q[$];

  always #5 clk = ~clk;

  regfile_wport_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  regfile_wport_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_hit(input logic [ADDR_W-1:0] a);
    if (a == '0) return 1'b0;
    foreach (lu_q[i]) if (lu_q[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  // Compare outputs at the falling edge, then advance the model at the rising edge.
  task automatic step();
    bit  claim, exp_we, acc, pop;
    wr_t e;
    int  sz;
    @(negedge clk);
    claim  = bus.wb_we && (bus.wb_addr != '0);
    sz     = lu_q.size();
    exp_we = rst_n && (claim || sz != 0);
    check_eq("rf_we", bus.rf_we, exp_we);
    if (exp_we && bus.rf_we) begin
      e = claim ? wb_q[0] : lu_q[0];
      check_eq("rf_waddr", bus.rf_waddr, e.a);
      check_eq("rf_wdata", bus.rf_wdata, e.d);
    end
    check_eq("fifo_count", bus.fifo_count, sz);
    check_eq("lu_ready", bus.lu_ready, sz < DEPTH);
    check_eq("stall_req", bus.stall_req, starve == SMAX);
    check_eq("pend_hit1", bus.pend_hit1, model_hit(bus.chk_addr1));
    check_eq("pend_hit2", bus.pend_hit2, model_hit(bus.chk_addr2));
    @(posedge clk);
    if (rst_n) begin
      acc = bus.lu_valid && (sz < DEPTH);
      pop = !claim && (sz != 0);
      if (pop || sz == 0) starve = 0;
      else if (claim && starve < SMAX) starve++;
      if (claim && wb_q.size() != 0) void'(wb_q.pop_front());
      if (pop) void'(lu_q.pop_front());
      if (acc && bus.lu_addr != '0) lu_q.push_back('{a: bus.lu_addr, d: bus.lu_data});
    end
    #1;
  endtask

  task automatic drive_step(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                            input logic lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld,
                            input logic [ADDR_W-1:0] c1, input logic [ADDR_W-1:0] c2);
    bus.wb_we = we;  bus.wb_addr = wa;  bus.wb_data = wd;
    bus.lu_valid = lv; bus.lu_addr = la; bus.lu_data = ld;
    bus.chk_addr1 = c1; bus.chk_addr2 = c2;
    if (rst_n && we && wa != '0) wb_q.push_back('{a: wa, d: wd});
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.wb_we = 0; bus.wb_addr = 0; bus.wb_data = 0;
    bus.lu_valid = 0; bus.lu_addr = 0; bus.lu_data = 0;
    bus.chk_addr1 = 0; bus.chk_addr2 = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_count", bus.fifo_count, 0);
    check_eq("rst_ready", bus.lu_ready, 1);
    check_eq("rst_stall", bus.stall_req, 0);
    check_eq("rst_rf_we", bus.rf_we, 0);
    rst_n = 1'b1;
    idle(1);

    // WB write is combinational to the register file.
    drive_step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    idle(1);

    // Single long-latency result, hazard visible while parked.
    drive_step(0, 0, 0, 1, 7, 32'h12345678, 7, 0);
    drive_step(0, 0, 0, 0, 0, 0, 7, 7);
    drive_step(0, 0, 0, 0, 0, 0, 7, 7);

    // Starvation: WB busy A..E, stall cycle F drains addr 3, G blocks, H drains addr 4.
    drive_step(1, 10, 32'hA0, 1, 3, 32'h33, 3, 4);
    drive_step(1, 11, 32'hA1, 1, 4, 32'h44, 3, 4);
    drive_step(1, 12, 32'hA2, 1, 5, 32'h55, 3, 4);
    drive_step(1, 13, 32'hA3, 0, 0, 0, 3, 4);
    drive_step(1, 14, 32'hA4, 0, 0, 0, 3, 4);
    drive_step(0, 0, 0, 0, 0, 0, 3, 4);
    drive_step(1, 15, 32'hA5, 0, 0, 0, 3, 4);
    drive_step(0, 0, 0, 0, 0, 0, 3, 4);
    idle(1);

    // Zero-register traffic on both sides.
    drive_step(1, 0, 32'hFFFF, 1, 0, 32'hEEEE, 0, 0);
    drive_step(0, 0, 0, 0, 0, 0, 0, 0);

    // WB ignoring stall_req: WB still wins, stall_req stays saturated.
    drive_step(1, 20, 32'hB0, 1, 9, 32'h99, 9, 0);
    for (int i = 0; i < 6; i++) drive_step(1, 21, 32'hB1 + i, 0, 0, 0, 9, 0);
    idle(2);

    // Fill FIFO, then asynchronous reset mid-cycle.
    drive_step(1, 22, 32'hC0, 1, 9, 32'h909, 9, 10);
    drive_step(1, 23, 32'hC1, 1, 10, 32'hA0A, 9, 10);
    bus.wb_we = 1; bus.wb_addr = 24; bus.wb_data = 32'hC2;
    #3 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_count", bus.fifo_count, 0);
    check_eq("mid_rst_stall", bus.stall_req, 0);
    check_eq("mid_rst_rf_we", bus.rf_we, 0);
    check_eq("mid_rst_ready", bus.lu_ready, 1);
    check_eq("mid_rst_hit", bus.pend_hit1, 0);
    lu_q.delete(); wb_q.delete(); starve = 0;
    step();
    drive_step(1, 24, 32'hC2, 1, 11, 32'hB, 9, 10);
    rst_n = 1'b1;
    idle(3);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      drive_step($urandom_range(0, 2) != 0 ? 1'b1 : 1'b0, ADDR_W'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), $urandom,
                 ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_wport_arbiter.md
# regfile_wport_arbiter

Shares the register file's single write port between the pipeline write-back stage and a long-latency unit (multiply/divide or load-return path). The write-back stage has fixed priority and is never back-pressured. Long-latency results are parked in a small FIFO and drain into free write-port cycles. A starvation counter requests a one-cycle pipeline freeze when a parked result waits too long, and hazard outputs let the stall logic detect reads of registers that still have pending writes. The block sits between the WB stage / long-latency unit and the register file's RegWrite_ctrl / WriteReg / WriteData inputs.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- DEPTH, 2, FIFO entries for long-latency results (power of two, ≥2)
- STARVE_MAX, 4, consecutive blocked cycles before stall request

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- wb_we  in  1  WB stage write request; always accepted
- wb_addr  in  ADDR_W  WB destination register
- wb_data  in  DATA_W  WB write data
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept a result this cycle
- lu_addr  in  ADDR_W  long-latency destination register
- lu_data  in  DATA_W  long-latency result
- rf_we  out  1  to register file RegWrite_ctrl
- rf_waddr  out  ADDR_W  to register file WriteReg
- rf_wdata  out  DATA_W  to register file WriteData
- stall_req  out  1  request to freeze WB producer for one cycle
- chk_addr1, chk_addr2  in  ADDR_W  source registers of the instruction in decode
- pend_hit1, pend_hit2  out  1  a pending FIFO write targets chk_addrN
- fifo_count  out  clog2(DEPTH)+1  occupied FIFO entries

## Operation
- WB claims the port when wb_we=1 and wb_addr≠0. In that case rf_* equals wb_* combinationally, in the same cycle.
- A write with wb_addr=0 is treated as an idle port. rf_we stays 0 unless the FIFO drains.
- When WB does not claim the port and the FIFO is non-empty, the FIFO head drives rf_*, with rf_we=1, and the head is popped at the clock edge.
- Long-latency accept: lu_valid & lu_ready at the clock edge.
  - A nonzero address is enqueued.
  - lu_addr=0 is accepted and discarded, with no enqueue.
  - There is no bypass: a result always spends at least one cycle in the FIFO.
- lu_ready = (fifo_count < DEPTH), computed from the registered count. When the FIFO is full, lu_ready is 0 even if a pop happens that cycle.
- Simultaneous push and pop on a non-full FIFO: fifo_count is unchanged and ordering is preserved (FIFO order).
- Starvation counter starve_cnt:
  - Increments, saturating at STARVE_MAX, on each cycle where the FIFO is non-empty and WB claims the port.
  - Clears on any pop or when the FIFO is empty.
- stall_req = (starve_cnt == STARVE_MAX). It is registered-state only, with no combinational path from inputs.
- The pipeline holds wb_we=0 while stall_req=1. If wb_we=1 anyway, WB still wins and stall_req stays high; the block still produces no corrupted write.
- pend_hitN = 1 when chk_addrN≠0 and any valid FIFO entry has addr == chk_addrN. This is combinational and does not include the entry being pushed in the current cycle.
- The block never reorders writes. Resolving WAW between WB and parked entries to the same register is the job of the hazard unit, using pend_hit.

## Timing
- Reset (rst=0, async) clears:
  - FIFO (fifo_count=0, all entries invalid)
  - starve_cnt=0, stall_req=0
  - rf_we forced 0 while rst=0
  - lu_ready=1, pend_hit1/2=0
- WB-to-register-file latency: 0 cycles (combinational).
- Long-latency minimum latency: accept at edge N, written at edge N+1 if WB is idle in cycle N+1.
- Starvation sequence with STARVE_MAX=4: head is blocked for 4 cycles, stall_req=1 in the 5th cycle, the head drains in that cycle, and stall_req=0 in the 6th cycle.
- Reset asserted mid-operation discards parked results. No write to the register file occurs after the reset edge.

## Test plan
- Reset, then wb_we=1, wb_addr=5, wb_data=0xDEADBEEF → rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in the same cycle; fifo_count=0.
- WB idle; push lu_addr=7, lu_data=0x12345678 → fifo_count=1 and pend_hit1=1 for chk_addr1=7; next cycle rf_we=1 with rf_waddr=7; then fifo_count=0 and pend_hit1=0.
- Push two results (addr 3, then addr 4) while WB writes every cycle → lu_ready=0 at count 2; stall_req rises after 4 blocked cycles; addr 3 is written in the stall cycle; stall_req falls; addr 4 is written when WB is next idle.
- lu_valid with lu_addr=0, and wb_we with wb_addr=0 → nothing enqueued, rf_we=0, pend_hit stays 0 for chk_addr=0.
- FIFO full (count 2), rst pulsed low mid-cycle → fifo_count=0, stall_req=0 and rf_we=0 immediately; lu_ready=1; no write of the parked data after reset is released.
